mem_bist_ctrl: RTL and testbench
================================

// Module: mem_bist_ctrl
// PURPOSE
// - Hardware memory self-test engine. Sits directly upstream of the 32x8 single-port memory
//   and drives its addr/data_in/read/write pins, then checks its data_out.
// - Runs CLEAR (all 0) and DATA=ADDRESS write/read-back/compare passes.
// - Reports busy/done/pass and an error count, so the memory is tested in silicon without a bench.
// PARAMETERS
// - ADDR_WIDTH  5  memory address width; DEPTH = 2**ADDR_WIDTH
// - DATA_WIDTH  8  memory data width
// - RD_LAT      1  memory read latency in cycles (>=1); data_out valid RD_LAT cycles after read=1
// - ERR_W       8  error counter width
// PORTS
// - clk          in   1           single clock, all logic on rising edge
// - rst          in   1           synchronous, active-high reset
// - start        in   1           pulse; starts a test when idle
// - busy         out  1           1 from the cycle after start is accepted until done
// - done         out  1           1-cycle pulse at end of test
// - pass         out  1           1 if err_count==0 at done; held until the next start
// - err_count    out  ERR_W       mismatches in this run, saturating
// - mem_addr     out  ADDR_WIDTH  memory address
// - mem_data_in  out  DATA_WIDTH  write data to memory
// - mem_write    out  1           memory write strobe
// - mem_read     out  1           memory read strobe
// - mem_data_out in   DATA_WIDTH  read data from memory
// BEHAVIOUR
// - All outputs are registered. Reset values: busy=0, done=0, pass=0, err_count=0, mem_addr=0,
//   mem_data_in=0, mem_write=0, mem_read=0. FSM goes to IDLE on reset.
// - FSM states: IDLE, WR, RD, WAIT, CMP, DONE.
//   IDLE -(start)-> WR with phase=CLEAR, addr=0, err_count=0, pass=0.
// - WR: mem_write=1 for 1 cycle, mem_data_in=pattern(phase,addr). -> RD.
// - RD: mem_read=1 for 1 cycle, mem_write=0. -> WAIT if RD_LAT>1, else -> CMP.
// - WAIT: RD_LAT-1 cycles, strobes 0. -> CMP.
// - CMP: sample mem_data_out and compare with pattern.
//   - On mismatch, increment err_count, saturating at 2**ERR_W-1.
//   - If addr==DEPTH-1: go to the next phase with addr=0 and state WR, or to DONE after the last phase.
//   - Otherwise: addr+1, state WR.
// - DONE: done=1 and pass=(err_count==0 incl. final compare), busy=0. -> IDLE.
// - Patterns:
//   - CLEAR = 0.
//   - DATA=ADDRESS = addr zero-extended to DATA_WIDTH, or truncated if ADDR_WIDTH > DATA_WIDTH.
// - Cycles per address = 2+RD_LAT; per phase = DEPTH*(2+RD_LAT).
//   Default: 96 cycles per phase, done 193 cycles after the start sample.
// - start while busy or in DONE: ignored. mem_read and mem_write are never 1 in the same cycle.
// - Address wraps only through the phase change; it never passes DEPTH-1 inside a phase.
// - rst mid-test: FSM to IDLE and all outputs to reset values next edge. No done pulse.
//   Memory contents are left as-is.
// CONFIGURATION
// - MEM_BIST_INV_PHASE_EN defined: a third phase INV_ADDR runs after DATA=ADDRESS.
//   - Its pattern is ~(DATA=ADDRESS pattern).
//   - Default total run = 3*96 cycles; done 289 cycles after start.
// - MEM_BIST_INV_PHASE_EN undefined: two phases only; done 193 cycles after start.
// TESTING (behavioural memory model, RD_LAT=1 and 3, defaults otherwise)
// - Good memory, start pulse -> busy=1 for the run.
//   - done once at cycle 193 (289 with the macro); pass=1, err_count=0.
//   - Final memory[k]=k (~k with the macro).
// - Model bit0 stuck-at-1 on addr 5 -> CLEAR fails at addr 5 only.
//   - err_count=1, pass=0 (err_count=2 with the macro: INV fails at 5, expected FA).
// - Model ignores writes to addr 31 (init 8'hFF) -> err_count=2 (CLEAR and DATA=ADDRESS), pass=0.
// - Every location faulty, ERR_W=4 -> err_count saturates at 15, pass=0.
// - start re-pulsed at cycle 50 -> ignored; done still at cycle 193.
//   Assert rst at cycle 100 -> busy=0 next cycle, no done; a fresh start gives a full pass.
// - Every cycle: never mem_read&&mem_write. Each mem_read is followed by exactly one CMP
//   RD_LAT cycles later.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl -- built-in self-test engine for a single-port memory.
//
// Drives the memory address/data/strobe pins directly and checks the read
// data. A run writes each location, reads it back and compares it, one
// address at a time. There are two passes: CLEAR (all zeros), then
// DATA=ADDRESS. Mismatches go into a saturating error counter, and a one-cycle
// done pulse ends the run, with pass valid from that point.
//
// Optional build macro:
//   MEM_BIST_INV_PHASE_EN  adds a third pass, INV_ADDR, that uses the
//                          pattern ~(DATA=ADDRESS).
//
// Ports:
//   clk           in   clock, all logic on the rising edge
//   rst           in   synchronous active-high reset
//   start         in   pulse, starts a run when idle
//   busy          out  high while a run is in progress
//   done          out  one-cycle pulse at the end of a run
//   pass          out  run finished with zero mismatches (held until next start)
//   err_count     out  saturating mismatch count for the current run
//   mem_addr      out  memory address
//   mem_data_in   out  memory write data
//   mem_write     out  memory write strobe
//   mem_read      out  memory read strobe
//   mem_data_out  in   memory read data, valid RD_LAT cycles after mem_read
module mem_bist_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam int EXT_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int WAIT_W = 16;

`ifdef MEM_BIST_INV_PHASE_EN
    localparam logic [1:0] LAST_PHASE = 2'd2;
`else
    localparam logic [1:0] LAST_PHASE = 2'd1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t              state;
    logic [1:0]          phase;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DATA_WIDTH-1:0] expected;
    logic                mismatch;
    logic [ERR_W-1:0]    err_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Test pattern for a phase/address pair. The address is zero-extended,
    // or truncated when it is wider than the data.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] ph,
                                                      input logic [ADDR_WIDTH-1:0] a);
        logic [EXT_W-1:0]      ext;
        logic [DATA_WIDTH-1:0] base;
        ext  = EXT_W'(a);
        base = ext[DATA_WIDTH-1:0];
        case (ph)
            2'd0:    pattern = '0;
            2'd1:    pattern = base;
            default: pattern = ~base;
        endcase
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        sat_inc = (&c) ? c : c + 1'b1;
    endfunction

    assign expected  = pattern(phase, mem_addr);
    assign mismatch  = (mem_data_out != expected);
    assign err_next  = mismatch ? sat_inc(err_count) : err_count;
    assign addr_next = mem_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= 2'd0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
        end else begin
            // Strobes and done are single-cycle unless a state re-asserts them.
            done      <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_WR;
                        phase       <= 2'd0;
                        mem_addr    <= '0;
                        err_count   <= '0;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                        mem_write   <= 1'b1;
                        mem_data_in <= pattern(2'd0, '0);
                    end
                end
                S_WR: begin
                    mem_read <= 1'b1;
                    state    <= S_RD;
                end
                S_RD: begin
                    if (RD_LAT > 1) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_W'(RD_LAT - 2);
                    end else begin
                        state <= S_CMP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_CMP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CMP: begin
                    err_count <= err_next;
                    if (&mem_addr) begin
                        if (phase == LAST_PHASE) begin
                            state <= S_DONE;
                        end else begin
                            // The address wraps only here, at a phase change.
                            phase       <= phase + 2'd1;
                            mem_addr    <= '0;
                            state       <= S_WR;
                            mem_write   <= 1'b1;
                            mem_data_in <= pattern(phase + 2'd1, '0);
                        end
                    end else begin
                        mem_addr    <= addr_next;
                        state       <= S_WR;
                        mem_write   <= 1'b1;
                        mem_data_in <= pattern(phase, addr_next);
                    end
                end
                S_DONE: begin
                    // err_count already includes the final compare.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Testbench for mem_bist_ctrl. Three instances share clk/rst/start:
// u1 (RD_LAT=1, ERR_W=8), u3 (RD_LAT=3, ERR_W=8) and u4 (RD_LAT=1, ERR_W=4).
// Each instance has its own behavioural memory. All three memories use the
// same fault mode:
//   0 good, 1 bit0 stuck-at-1 at addr 5, 2 writes to addr 31 ignored
//   (init FF), 3 bit7 stuck-at-1 everywhere.
// A reference model computes the expected error counts and the final memory
// contents from the pattern rules.
module tb_mem_bist_ctrl;

`ifdef MEM_BIST_INV_PHASE_EN
    localparam int NPH = 3;
`else
    localparam int NPH = 2;
`endif

    logic clk = 1'b0;
    logic rst, start, prep;
    int   fault_mode;
    logic [7:0] ini [32];

    logic       busy1, done1, pass1, wr1, rd1;
    logic [7:0] err1, din1, dout1;
    logic [4:0] addr1;
    logic       busy3, done3, pass3, wr3, rd3;
    logic [7:0] err3, din3, dout3;
    logic [4:0] addr3;
    logic       busy4, done4, pass4, wr4, rd4;
    logic [3:0] err4;
    logic [7:0] din4, dout4;
    logic [4:0] addr4;

    logic [7:0] mem1 [32];
    logic [7:0] mem3 [32];
    logic [7:0] mem4 [32];
    logic [7:0] pipe1, pipe4;
    logic [7:0] pipe3 [3];

    int cyc = 0;
    int dn1, dn3, dn4, at1, at3, at4, nr1, nr3, nr4, nw1, nw3, nw4, conf;
    int tests = 0;
    int failed = 0;
    logic [7:0] ref_mem [32];
    int ref_err;

    always #5 clk = ~clk;

    mem_bist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LAT(1), .ERR_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .mem_addr(addr1), .mem_data_in(din1), .mem_write(wr1),
        .mem_read(rd1), .mem_data_out(dout1));
    mem_bist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LAT(3), .ERR_W(8)) u3 (
        .clk(clk), .rst(rst), .start(start), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .mem_addr(addr3), .mem_data_in(din3), .mem_write(wr3),
        .mem_read(rd3), .mem_data_out(dout3));
    mem_bist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LAT(1), .ERR_W(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .mem_addr(addr4), .mem_data_in(din4), .mem_write(wr4),
        .mem_read(rd4), .mem_data_out(dout4));

    function automatic logic [7:0] fread(input logic [4:0] a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (fault_mode == 1 && a == 5'd5) r[0] = 1'b1;
        if (fault_mode == 3) r[7] = 1'b1;
        return r;
    endfunction

    function automatic logic wr_ok(input logic [4:0] a);
        return !(fault_mode == 2 && a == 5'd31);
    endfunction

    // Behavioural memories. Read data is delayed RD_LAT cycles, and slots
    // with no read in progress hold junk.
    always @(posedge clk) begin
        if (prep) begin
            for (int k = 0; k < 32; k++) mem1[k] <= ini[k];
        end else if (wr1 && wr_ok(addr1)) begin
            mem1[addr1] <= din1;
        end
        pipe1 <= rd1 ? fread(addr1, mem1[addr1]) : 8'hA5;
    end
    assign dout1 = pipe1;

    always @(posedge clk) begin
        if (prep) begin
            for (int k = 0; k < 32; k++) mem3[k] <= ini[k];
        end else if (wr3 && wr_ok(addr3)) begin
            mem3[addr3] <= din3;
        end
        pipe3[0] <= rd3 ? fread(addr3, mem3[addr3]) : 8'hA5;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout3 = pipe3[2];

    always @(posedge clk) begin
        if (prep) begin
            for (int k = 0; k < 32; k++) mem4[k] <= ini[k];
        end else if (wr4 && wr_ok(addr4)) begin
            mem4[addr4] <= din4;
        end
        pipe4 <= rd4 ? fread(addr4, mem4[addr4]) : 8'hA5;
    end
    assign dout4 = pipe4;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (prep) begin
            dn1 = 0; dn3 = 0; dn4 = 0; at1 = 0; at3 = 0; at4 = 0;
            nr1 = 0; nr3 = 0; nr4 = 0; nw1 = 0; nw3 = 0; nw4 = 0; conf = 0;
        end else begin
            if (done1) begin dn1++; at1 = cyc; end
            if (done3) begin dn3++; at3 = cyc; end
            if (done4) begin dn4++; at4 = cyc; end
            if (rd1) nr1++;
            if (rd3) nr3++;
            if (rd4) nr4++;
            if (wr1) nw1++;
            if (wr3) nw3++;
            if (wr4) nw4++;
            if ((rd1 && wr1) || (rd3 && wr3) || (rd4 && wr4)) conf++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model. Replays the passes on an array memory that has the
    // same fault, and counts read-back mismatches.
    task automatic ref_run(input int mode);
        logic [7:0] pat, rdv;
        ref_err = 0;
        for (int k = 0; k < 32; k++) ref_mem[k] = ini[k];
        for (int ph = 0; ph < NPH; ph++) begin
            for (int a = 0; a < 32; a++) begin
                pat = (ph == 0) ? 8'h00 : (ph == 1) ? 8'(a) : ~8'(a);
                if (!(mode == 2 && a == 31)) ref_mem[a] = pat;
                rdv = ref_mem[a];
                if (mode == 1 && a == 5) rdv = rdv | 8'h01;
                if (mode == 3) rdv = rdv | 8'h80;
                if (rdv != pat) ref_err++;
            end
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic prep_run(input int mode);
        fault_mode = mode;
        for (int k = 0; k < 32; k++) ini[k] = 8'($urandom);
        if (mode == 2) ini[31] = 8'hFF;
        prep = 1'b1;
        step(1);
        prep = 1'b0;
        ref_run(mode);
        step($urandom_range(0, 5));
    endtask

    task automatic run_test(input int mode);
        int t0, extra, bad3, bad4;
        bit fin;
        prep_run(mode);
        extra = $urandom_range(2, 180);
        start = 1'b1;
        step(1);
        t0 = cyc;
        chk($sformatf("m%0d busy_after_start", mode), busy1, 1);
        start = 1'b0;
        fin = 1'b0;
        // Re-pulse start at cycle 50 and at a random cycle. Both must be ignored.
        for (int i = 1; i < 1500; i++) begin
            if (dn1 > 0 && dn3 > 0 && dn4 > 0) begin
                fin = 1'b1;
                break;
            end
            start = (i == 50 || i == extra);
            step(1);
        end
        start = 1'b0;
        chk($sformatf("m%0d all_done_in_budget", mode), fin, 1);
        step(5);
        chk($sformatf("m%0d done_count_u1", mode), dn1, 1);
        chk($sformatf("m%0d done_count_u3", mode), dn3, 1);
        chk($sformatf("m%0d done_count_u4", mode), dn4, 1);
        chk($sformatf("m%0d latency_u1", mode), at1 - t0, NPH * 32 * 3 + 1);
        chk($sformatf("m%0d latency_u3", mode), at3 - t0, NPH * 32 * 5 + 1);
        chk($sformatf("m%0d busy_after_done", mode), {busy1, busy3, busy4}, 0);
        chk($sformatf("m%0d err_u1", mode), err1, sat(ref_err, 8));
        chk($sformatf("m%0d err_u3", mode), err3, sat(ref_err, 8));
        chk($sformatf("m%0d err_u4", mode), err4, sat(ref_err, 4));
        chk($sformatf("m%0d pass_u1", mode), pass1, (ref_err == 0));
        chk($sformatf("m%0d pass_u3", mode), pass3, (ref_err == 0));
        chk($sformatf("m%0d pass_u4", mode), pass4, (ref_err == 0));
        chk($sformatf("m%0d reads_u1", mode), nr1, NPH * 32);
        chk($sformatf("m%0d reads_u3", mode), nr3, NPH * 32);
        chk($sformatf("m%0d writes_u1", mode), nw1, NPH * 32);
        chk($sformatf("m%0d writes_u3", mode), nw3, NPH * 32);
        chk($sformatf("m%0d rw_conflicts", mode), conf, 0);
        bad3 = 0;
        bad4 = 0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("m%0d mem1[%0d]", mode, k), mem1[k], ref_mem[k]);
            if (mem3[k] !== ref_mem[k]) bad3++;
            if (mem4[k] !== ref_mem[k]) bad4++;
        end
        chk($sformatf("m%0d mem3_bad_locs", mode), bad3, 0);
        chk($sformatf("m%0d mem4_bad_locs", mode), bad4, 0);
        step($urandom_range(1, 10));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        prep = 1'b0;
        fault_mode = 0;
        for (int k = 0; k < 32; k++) ini[k] = 8'h00;
        step(3);
        chk("rst busy", busy1, 0);
        chk("rst done", done1, 0);
        chk("rst pass", pass1, 0);
        chk("rst err_count", err1, 0);
        chk("rst mem_addr", addr1, 0);
        chk("rst mem_data_in", din1, 0);
        chk("rst mem_write", wr1, 0);
        chk("rst mem_read", rd1, 0);
        rst = 1'b0;
        step(2);

        run_test(0);
        run_test(1);
        run_test(2);
        run_test(3);

        // Reset in the middle of a run: outputs clear, and no done pulse follows.
        prep_run(0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(99);
        chk("midrst busy_before", busy1, 1);
        rst = 1'b1;
        step(1);
        chk("midrst busy", {busy1, busy3, busy4}, 0);
        chk("midrst strobes", {wr1, rd1, wr3, rd3}, 0);
        chk("midrst err_count", err1, 0);
        chk("midrst mem_addr", addr1, 0);
        chk("midrst done", done1, 0);
        rst = 1'b0;
        step(400);
        chk("midrst no_done_u1", dn1, 0);
        chk("midrst no_done_u3", dn3, 0);
        chk("midrst still_idle", busy3, 0);

        // A fresh start after the interrupted run gives a full pass.
        run_test(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
